// File: rtl/im_pkg.sv
// rtl/im_pkg.sv - shared types, FSM encodings and helpers for the image scaling stages
package im_pkg;

  localparam int PIXEL_W = 24;
  typedef logic [PIXEL_W-1:0] pixel_t;

  localparam logic [2:0] EXP_IDLE = 3'd0;
  localparam logic [2:0] EXP_LOAD = 3'd1;
  localparam logic [2:0] EXP_WAIT = 3'd2;
  localparam logic [2:0] EXP_EMIT = 3'd3;
  localparam logic [2:0] EXP_DONE = 3'd4;

  function automatic int c2(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/im_line_buffer.sv
// rtl/im_line_buffer.sv - one-row pixel store with registered, write-first read port
module im_line_buffer
  import im_pkg::*;
#(
  parameter int pDEPTH  = 160,
  parameter int pDATA_W = 24
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  iwr_en,
  input  logic [c2(pDEPTH)-1:0] iwr_addr,
  input  logic [pDATA_W-1:0]    iwr_data,
  input  logic                  ird_en,
  input  logic [c2(pDEPTH)-1:0] ird_addr,
  output logic [pDATA_W-1:0]    ord_data
);

  logic [pDATA_W-1:0] mem [pDEPTH];

  always_ff @(posedge iclk) begin
    if (iwr_en) mem[iwr_addr] <= iwr_data;
  end

  // Bypass covers a one-pixel-wide row, where the final capture and first replay coincide.
  always_ff @(posedge iclk) begin
    if (irst)
      ord_data <= '0;
    else if (ird_en)
      ord_data <= (iwr_en && (iwr_addr == ird_addr)) ? iwr_data : mem[ird_addr];
  end

endmodule

// File: rtl/im_expansion.sv
// rtl/im_expansion.sv - nearest-neighbour upscaler: fetch one source row, replay it SY times widened by SX
module im_expansion
  import im_pkg::*;
#(
  parameter int pIN_IM_WIDTH   = 160,
  parameter int pIN_IM_HEIGHT  = 120,
  parameter int pOUT_IM_WIDTH  = 640,
  parameter int pOUT_IM_HEIGHT = 480,
  parameter int pDATA_W        = 24,
  parameter int pRD_LATENCY    = 1
) (
  input  logic                                              iclk,
  input  logic                                              irst,
  input  logic [pDATA_W-1:0]                                idata_rd,
  output logic [c2(pIN_IM_WIDTH*pIN_IM_HEIGHT)-1:0]         oaddr_rd,
  output logic                                              omem_rd_en,
  output logic [pDATA_W-1:0]                                odata_wr,
  output logic [c2(pOUT_IM_WIDTH*pOUT_IM_HEIGHT)-1:0]       oaddr_wr,
  output logic                                              omem_wr_en,
  input  logic                                              istart_work,
  output logic                                              omodule_work_f,
  output logic                                              omodule_done_f
);

  localparam int SX  = pOUT_IM_WIDTH / pIN_IM_WIDTH;
  localparam int SY  = pOUT_IM_HEIGHT / pIN_IM_HEIGHT;
  localparam int CW  = c2(pIN_IM_WIDTH);
  localparam int RW  = c2(pIN_IM_HEIGHT);
  localparam int LW  = c2(pRD_LATENCY);
  localparam int OCW = c2(pOUT_IM_WIDTH);
  localparam int SXW = c2(SX);
  localparam int SYW = c2(SY);
  localparam int WAW = c2(pOUT_IM_WIDTH*pOUT_IM_HEIGHT);

  localparam logic [CW-1:0]  COL_LAST  = CW'(pIN_IM_WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(pIN_IM_HEIGHT - 1);
  localparam logic [LW-1:0]  WAIT_LAST = LW'(pRD_LATENCY - 1);
  localparam logic [OCW-1:0] OCOL_LAST = OCW'(pOUT_IM_WIDTH - 1);
  localparam logic [SXW-1:0] SX_LAST   = SXW'(SX - 1);
  localparam logic [SYW-1:0] SY_LAST   = SYW'(SY - 1);

  if (SX < 1 || SX * pIN_IM_WIDTH != pOUT_IM_WIDTH) begin : g_bad_sx
    $error("im_expansion: output width is not an integer multiple of input width");
  end
  if (SY < 1 || SY * pIN_IM_HEIGHT != pOUT_IM_HEIGHT) begin : g_bad_sy
    $error("im_expansion: output height is not an integer multiple of input height");
  end

  logic [2:0]     state;
  logic [CW-1:0]  col;
  logic [RW-1:0]  src_row;
  logic [LW-1:0]  wait_cnt;
  logic [OCW-1:0] out_col;
  logic [SXW-1:0] sub_x;
  logic [CW-1:0]  src_col;
  logic [SYW-1:0] sub_y;
  logic [WAW-1:0] wr_addr;
  logic           emit_end;
  logic           issue;
  logic           issue_last;

  logic [pRD_LATENCY-1:0] vld_pipe;
  logic [CW-1:0]          col_pipe [pRD_LATENCY];

  assign omem_rd_en = (state == EXP_LOAD);

  // Write port is registered, so the emit counters describe the pixel launched at the next edge.
  assign issue      = ((state == EXP_WAIT) && (wait_cnt == WAIT_LAST)) ||
                      ((state == EXP_EMIT) && !emit_end);
  assign issue_last = (out_col == OCOL_LAST) && (sub_y == SY_LAST);

  always_ff @(posedge iclk) begin
    if (irst) begin
      vld_pipe <= '0;
      for (int i = 0; i < pRD_LATENCY; i++) col_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= omem_rd_en;
      col_pipe[0] <= col;
      for (int i = 1; i < pRD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        col_pipe[i] <= col_pipe[i-1];
      end
    end
  end

  im_line_buffer #(
    .pDEPTH  (pIN_IM_WIDTH),
    .pDATA_W (pDATA_W)
  ) u_line_buffer (
    .iclk     (iclk),
    .irst     (irst),
    .iwr_en   (vld_pipe[pRD_LATENCY-1]),
    .iwr_addr (col_pipe[pRD_LATENCY-1]),
    .iwr_data (idata_rd),
    .ird_en   (issue),
    .ird_addr (src_col),
    .ord_data (odata_wr)
  );

  always_ff @(posedge iclk) begin
    if (irst) begin
      state          <= EXP_IDLE;
      col            <= '0;
      src_row        <= '0;
      wait_cnt       <= '0;
      out_col        <= '0;
      sub_x          <= '0;
      src_col        <= '0;
      sub_y          <= '0;
      wr_addr        <= '0;
      emit_end       <= 1'b0;
      oaddr_rd       <= '0;
      oaddr_wr       <= '0;
      omem_wr_en     <= 1'b0;
      omodule_work_f <= 1'b0;
      omodule_done_f <= 1'b0;
    end else begin
      omem_wr_en <= issue;
      if (issue) begin
        oaddr_wr <= wr_addr;
        emit_end <= issue_last;
        if (!(issue_last && src_row == ROW_LAST)) wr_addr <= wr_addr + 1'b1;
        if (out_col == OCOL_LAST) begin
          out_col <= '0;
          sub_x   <= '0;
          src_col <= '0;
          sub_y   <= (sub_y == SY_LAST) ? '0 : sub_y + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
          if (sub_x == SX_LAST) begin
            sub_x   <= '0;
            src_col <= src_col + 1'b1;
          end else begin
            sub_x <= sub_x + 1'b1;
          end
        end
      end

      case (state)
        EXP_IDLE: begin
          omodule_done_f <= 1'b0;
          if (istart_work) begin
            state          <= EXP_LOAD;
            omodule_work_f <= 1'b1;
            col            <= '0;
            src_row        <= '0;
            oaddr_rd       <= '0;
            wr_addr        <= '0;
            out_col        <= '0;
            sub_x          <= '0;
            src_col        <= '0;
            sub_y          <= '0;
          end
        end
        EXP_LOAD: begin
          col <= col + 1'b1;
          if (!(col == COL_LAST && src_row == ROW_LAST)) oaddr_rd <= oaddr_rd + 1'b1;
          if (col == COL_LAST) begin
            col      <= '0;
            wait_cnt <= '0;
            state    <= EXP_WAIT;
          end
        end
        EXP_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) state <= EXP_EMIT;
        end
        EXP_EMIT: begin
          if (emit_end) begin
            emit_end <= 1'b0;
            if (src_row == ROW_LAST) begin
              state          <= EXP_DONE;
              omodule_work_f <= 1'b0;
              omodule_done_f <= 1'b1;
            end else begin
              src_row <= src_row + 1'b1;
              state   <= EXP_LOAD;
            end
          end
        end
        EXP_DONE: begin
          omodule_done_f <= 1'b0;
          state          <= EXP_IDLE;
        end
        default: state <= EXP_IDLE;
      endcase
    end
  end

endmodule
